// File: rtl/axis_seq_checker_pkg.sv
// Shared definitions for the AXI-Stream sequence checker: FSM encodings and LFSR taps.
package axis_seq_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  // Fibonacci taps 16,14,13,11 expressed as a mask over state bits [15],[13],[12],[10].
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/axis_seq_checker_lfsr16.sv
// 16-bit Fibonacci LFSR used as the pseudo-random backpressure source (module axis_lfsr16).
module axis_lfsr16
  import axis_seq_checker_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  input  logic        advance,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= seed;
    end else if (advance) begin
      state <= {state[14:0], ^(state & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/axis_seq_checker.sv
// AXI-Stream receive checker: verifies an incrementing data sequence and counts beats/errors.
// Optional pseudo-random backpressure is built when AXIS_SEQ_CHECKER_BACKPRESSURE_EN is defined.
module axis_seq_checker
  import axis_seq_checker_pkg::*;
#(
  parameter int              AXIS_WIDTH    = 32,
  parameter int              CNT_WIDTH     = 16,
  parameter int              STEP          = 1,
  parameter int              SYNC_ON_FIRST = 0,
  parameter logic [15:0]     LFSR_SEED     = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [AXIS_WIDTH-1:0] init_data,
  input  logic                  s_axis_tvalid,
  input  logic [AXIS_WIDTH-1:0] s_axis_tdata,
  output logic                  s_axis_tready,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  err,
  output logic [AXIS_WIDTH-1:0] last_bad_data
);

  localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;
  localparam logic [AXIS_WIDTH-1:0] STEP_V  = AXIS_WIDTH'(STEP);

  state_t                state;
  state_t                next_state;
  logic [AXIS_WIDTH-1:0] expected;
  logic                  accept;
  logic                  throttle;

`ifdef AXIS_SEQ_CHECKER_BACKPRESSURE_EN
  logic [15:0] lfsr_state;

  axis_lfsr16 u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .seed    (LFSR_SEED),
    .advance (state != ST_IDLE),
    .state   (lfsr_state)
  );

  assign throttle = lfsr_state[0];
`else
  assign throttle = 1'b1;
`endif

  assign accept = s_axis_tvalid & s_axis_tready;

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (en) next_state = (SYNC_ON_FIRST != 0) ? ST_SYNC : ST_CHECK;
      ST_SYNC:  if (!en) next_state = ST_IDLE;
                else if (accept) next_state = ST_CHECK;
      ST_CHECK: if (!en) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // A beat accepted on the edge that drops en is still counted and checked.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      expected      <= '0;
      s_axis_tready <= 1'b0;
      beat_count    <= '0;
      err_count     <= '0;
      err           <= 1'b0;
      last_bad_data <= '0;
    end else begin
      state         <= next_state;
      s_axis_tready <= (next_state != ST_IDLE) & throttle;

      if (state == ST_IDLE && en && SYNC_ON_FIRST == 0) begin
        expected <= init_data;
      end

      if (accept && state != ST_IDLE) begin
        if (beat_count != CNT_MAX) beat_count <= beat_count + 1'b1;
        // Always resync on received data so a single bad beat costs one error.
        expected <= s_axis_tdata + STEP_V;
        if (state == ST_CHECK && s_axis_tdata != expected) begin
          if (err_count != CNT_MAX) err_count <= err_count + 1'b1;
          err           <= 1'b1;
          last_bad_data <= s_axis_tdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_seq_checker.sv
// Self-checking bench for axis_seq_checker: randomized streams against a behavioural model.
module tb_axis_seq_checker;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [31:0] init_data;
  logic        s_axis_tvalid;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tready;
  logic [CNT_W-1:0] beat_count;
  logic [CNT_W-1:0] err_count;
  logic        err;
  logic [31:0] last_bad_data;

  int checks = 0;
  int passes = 0;

  // Reference model state
  int          m_beats;
  int          m_errs;
  logic        m_err;
  logic [31:0] m_last;
  logic [31:0] m_exp;
  bit          m_armed;

  bit last_hs;
  bit gaps_on;

  axis_seq_checker #(
    .AXIS_WIDTH    (32),
    .CNT_WIDTH     (CNT_W),
    .STEP          (1),
    .SYNC_ON_FIRST (0),
    .LFSR_SEED     (16'hACE1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .init_data     (init_data),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tready (s_axis_tready),
    .beat_count    (beat_count),
    .err_count     (err_count),
    .err           (err),
    .last_bad_data (last_bad_data)
  );

  always #5 clk = ~clk;

  task automatic model_edge(input logic en_v, input bit hs, input logic [31:0] d);
    if (reset) begin
      m_beats = 0; m_errs = 0; m_err = 0; m_last = 0; m_exp = 0; m_armed = 0;
      return;
    end
    if (m_armed && hs) begin
      if (m_beats < CNT_MAX) m_beats++;
      if (d != m_exp) begin
        if (m_errs < CNT_MAX) m_errs++;
        m_err  = 1;
        m_last = d;
      end
      m_exp = d + 32'd1;
    end
    if (!m_armed && en_v) begin
      m_armed = 1;
      m_exp   = init_data;
    end else if (m_armed && !en_v) begin
      m_armed = 0;
    end
  endtask

  // Called at a negedge; drives inputs, crosses one posedge, returns at the next negedge.
  task automatic tick(input logic en_v, input logic v, input logic [31:0] d);
    bit hs;
    en            = en_v;
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    hs = v && (s_axis_tready === 1'b1);
    @(posedge clk);
    model_edge(en_v, hs, d);
    last_hs = hs;
    @(negedge clk);
  endtask

  task automatic send_beat(input logic [31:0] d);
    bit done = 0;
    int n = 0;
    while (!done && n < 64) begin
      if (gaps_on && $urandom_range(0, 3) == 0) tick(1'b1, 1'b0, $urandom);
      else begin
        tick(1'b1, 1'b1, d);
        done = last_hs;
      end
      n++;
    end
    if (!done) begin
      checks++;
      $display("[TB] FAIL send_timeout beat %h not accepted within 64 cycles", d);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1'b0, 1'b0, 32'd0);
    tick(1'b0, 1'b0, 32'd0);
    reset = 1'b0;
  endtask

  task automatic check_counts(input string name);
    checks++;
    if (beat_count !== CNT_W'(m_beats))
      $display("[TB] FAIL %s beat_count got %0d want %0d", name, beat_count, m_beats);
    else passes++;
    checks++;
    if (err_count !== CNT_W'(m_errs))
      $display("[TB] FAIL %s err_count got %0d want %0d", name, err_count, m_errs);
    else passes++;
    checks++;
    if (err !== m_err)
      $display("[TB] FAIL %s err got %b want %b", name, err, m_err);
    else passes++;
    checks++;
    if (last_bad_data !== m_last)
      $display("[TB] FAIL %s last_bad_data got %h want %h", name, last_bad_data, m_last);
    else passes++;
  endtask

  task automatic test_reset();
    do_reset();
    check_counts("reset");
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (s_axis_tready !== 1'b0)
        $display("[TB] FAIL reset_tready cycle %0d got %b want 0", i, s_axis_tready);
      else passes++;
      tick(1'b0, 1'b1, 32'd1);
    end
  endtask

  task automatic test_clean_stream();
    do_reset();
    init_data = 32'd1;
    tick(1'b1, 1'b0, 32'd0);
`ifndef AXIS_SEQ_CHECKER_BACKPRESSURE_EN
    checks++;
    if (s_axis_tready !== 1'b1)
      $display("[TB] FAIL clean_tready_rise got %b want 1", s_axis_tready);
    else passes++;
`endif
    gaps_on = 1;
    for (int i = 1; i <= 20; i++) send_beat(32'(i));
    tick(1'b1, 1'b0, 32'd0);
    check_counts("clean");
    checks++;
    if (beat_count !== 8'd20 || err_count !== 8'd0)
      $display("[TB] FAIL clean_totals got beats=%0d errs=%0d want 20/0", beat_count, err_count);
    else passes++;
  endtask

  task automatic test_error_injection();
    logic [31:0] seq [6] = '{32'd1, 32'd2, 32'd3, 32'd7, 32'd8, 32'd9};
    do_reset();
    init_data = 32'd1;
    for (int i = 0; i < 6; i++) send_beat(seq[i]);
    tick(1'b1, 1'b0, 32'd0);
    check_counts("errinj");
    checks++;
    if (err_count !== 8'd1 || last_bad_data !== 32'd7 || beat_count !== 8'd6)
      $display("[TB] FAIL errinj_totals got errs=%0d bad=%h beats=%0d want 1/7/6",
               err_count, last_bad_data, beat_count);
    else passes++;
  endtask

  task automatic test_wrap();
    logic [31:0] seq [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    do_reset();
    init_data = 32'hFFFF_FFFE;
    for (int i = 0; i < 4; i++) send_beat(seq[i]);
    tick(1'b1, 1'b0, 32'd0);
    check_counts("wrap");
    checks++;
    if (err_count !== 8'd0 || beat_count !== 8'd4)
      $display("[TB] FAIL wrap_totals got errs=%0d beats=%0d want 0/4", err_count, beat_count);
    else passes++;
  endtask

  task automatic test_rearm();
    do_reset();
    init_data = 32'd1;
    for (int i = 1; i <= 5; i++) send_beat(32'(i));
    tick(1'b0, 1'b1, 32'd6);
    checks++;
    if (s_axis_tready !== 1'b0)
      $display("[TB] FAIL rearm_tready_drop got %b want 0", s_axis_tready);
    else passes++;
    tick(1'b0, 1'b1, 32'd99);
    tick(1'b0, 1'b1, 32'd99);
    init_data = 32'd9;
    for (int i = 9; i <= 11; i++) send_beat(32'(i));
    tick(1'b1, 1'b0, 32'd0);
    check_counts("rearm");
    checks++;
    if (err_count !== 8'd0 || beat_count < 8'd8)
      $display("[TB] FAIL rearm_accumulate got errs=%0d beats=%0d want 0/>=8", err_count, beat_count);
    else passes++;
    send_beat(32'd12);
    reset = 1'b1;
    tick(1'b1, 1'b1, 32'd13);
    reset = 1'b0;
    tick(1'b0, 1'b0, 32'd0);
    checks++;
    if (beat_count !== 8'd0 || err_count !== 8'd0 || err !== 1'b0 || s_axis_tready !== 1'b0)
      $display("[TB] FAIL rearm_midreset got beats=%0d errs=%0d err=%b rdy=%b want 0/0/0/0",
               beat_count, err_count, err, s_axis_tready);
    else passes++;
  endtask

  task automatic test_random();
    logic [31:0] d;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      init_data = $urandom;
      d = init_data;
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(0, 5) == 0) send_beat(d ^ (32'd1 << $urandom_range(0, 31)));
        else send_beat(d);
        d = d + 32'd1 + (($urandom_range(0, 9) == 0) ? 32'd3 : 32'd0);
      end
      tick(1'b1, 1'b0, 32'd0);
      check_counts("random");
    end
  endtask

  task automatic test_saturation();
    do_reset();
    init_data = 32'd0;
    gaps_on = 0;
    for (int i = 0; i < 270; i++) send_beat(32'd5);
    tick(1'b1, 1'b0, 32'd0);
    check_counts("saturate");
    gaps_on = 1;
  endtask

  task automatic test_backpressure();
    int hi = 0;
    int lo = 0;
    logic [31:0] d;
    do_reset();
    init_data = 32'h100;
    d = init_data;
    tick(1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 200; i++) begin
      if (s_axis_tready === 1'b1) hi++; else lo++;
      tick(1'b1, 1'b1, d);
      if (last_hs) d = d + 32'd1;
    end
    tick(1'b1, 1'b0, 32'd0);
    check_counts("bp");
    checks++;
    if (beat_count !== CNT_W'(hi))
      $display("[TB] FAIL bp_ready_cycles got beats=%0d want %0d", beat_count, hi);
    else passes++;
`ifdef AXIS_SEQ_CHECKER_BACKPRESSURE_EN
    checks++;
    if (hi < 20 || lo < 20)
      $display("[TB] FAIL bp_toggle got hi=%0d lo=%0d want both >=20", hi, lo);
    else passes++;
`else
    checks++;
    if (lo !== 0)
      $display("[TB] FAIL bp_always_ready got low_cycles=%0d want 0", lo);
    else passes++;
`endif
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; init_data = '0; s_axis_tvalid = 1'b0; s_axis_tdata = '0;
    gaps_on = 1;
    @(negedge clk);
    test_reset();
    test_clean_stream();
    test_error_injection();
    test_wrap();
    test_rearm();
    test_random();
    test_saturation();
    test_backpressure();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
